gray_pixel_source: RTL and testbench

GRAY_PIXEL_SOURCE -- requirements
Module: gray_pixel_source

---
 rtl/gray_pixel_source_if.sv | 25 ++
 rtl/gray_pixel_source.sv | 158 +++++++++++++++
 tb/tb_gray_pixel_source.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/gray_pixel_source_if.sv
// Frame-buffer read port and video timing/pixel outputs of gray_pixel_source.
// master = the pixel source, slave = frame buffer plus video sink.
interface gray_pixel_source_if;
  logic        run;
  logic [16:0] rd_addr;
  logic        rd_en;
  logic [11:0] rd_data;
  logic [11:0] gray_in;
  logic [9:0]  x_coor;
  logic [8:0]  y_coor;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic        frame_start;

  modport master (
    input  run, rd_data,
    output rd_addr, rd_en, gray_in, x_coor, y_coor, de, hsync, vsync, frame_start
  );

  modport slave (
    output run, rd_data,
    input  rd_addr, rd_en, gray_in, x_coor, y_coor, de, hsync, vsync, frame_start
  );
endinterface

// File: rtl/gray_pixel_source.sv
// VGA-style timing generator that reads a 320x240 RGB444 frame buffer at 2x scale
// and emits grayscale pixels through a 3-stage pipeline (address, fetch, convert).
module gray_pixel_source #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic                 clk,
  input  logic                 reset,
  gray_pixel_source_if.master  bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  r_h_cnt, r_v_cnt;

  logic        w_active, w_hsync_n, w_vsync_n, w_fstart;
  logic [16:0] w_vh, w_hh, w_addr;

  logic [16:0] r_rd_addr;
  logic        r_rd_en, r_s1_hs, r_s1_vs, r_s1_fs;
  logic [9:0]  r_s1_x;
  logic [8:0]  r_s1_y;

  logic        r_s2_de, r_s2_hs, r_s2_vs, r_s2_fs;
  logic [9:0]  r_s2_x;
  logic [8:0]  r_s2_y;
  logic [11:0] r_s2_rgb;

  logic [7:0]  w_r8, w_g8, w_b8, w_sum;
  logic [3:0]  w_gray;
  logic        w_unused_lsb;

  logic [11:0] r_gray;
  logic [9:0]  r_x;
  logic [8:0]  r_y;
  logic        r_de, r_hs, r_vs, r_fs;

  // Counters park at (0,0) while run is low so a restart begins a fresh frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (!bus.run) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 10'd1;
    end
  end

  assign w_active  = bus.run && (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_hsync_n = !(bus.run && (r_h_cnt >= HS_START) && (r_h_cnt < HS_END));
  assign w_vsync_n = !(bus.run && (r_v_cnt >= VS_START) && (r_v_cnt < VS_END));
  assign w_fstart  = bus.run && (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);

  // row*320 as row*256 + row*64
  assign w_vh   = {8'd0, r_v_cnt[9:1]};
  assign w_hh   = {8'd0, r_h_cnt[9:1]};
  assign w_addr = (w_vh << 8) + (w_vh << 6) + w_hh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_addr <= '0;
      r_rd_en   <= 1'b0;
      r_s1_hs   <= 1'b1;
      r_s1_vs   <= 1'b1;
      r_s1_fs   <= 1'b0;
      r_s1_x    <= '0;
      r_s1_y    <= '0;
    end else begin
      r_rd_addr <= w_active ? w_addr : 17'd0;
      r_rd_en   <= w_active;
      r_s1_hs   <= w_hsync_n;
      r_s1_vs   <= w_vsync_n;
      r_s1_fs   <= w_fstart;
      r_s1_x    <= w_active ? r_h_cnt : 10'd0;
      r_s1_y    <= w_active ? r_v_cnt[8:0] : 9'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_de  <= 1'b0;
      r_s2_hs  <= 1'b1;
      r_s2_vs  <= 1'b1;
      r_s2_fs  <= 1'b0;
      r_s2_x   <= '0;
      r_s2_y   <= '0;
      r_s2_rgb <= '0;
    end else begin
      r_s2_de  <= r_rd_en;
      r_s2_hs  <= r_s1_hs;
      r_s2_vs  <= r_s1_vs;
      r_s2_fs  <= r_s1_fs;
      r_s2_x   <= r_s1_x;
      r_s2_y   <= r_s1_y;
      r_s2_rgb <= r_rd_en ? bus.rd_data : 12'd0;
    end
  end

  // 5R + 9G + 2B peaks at 240, so 8 bits never overflow and g tops out at 15.
  assign w_r8   = {4'd0, r_s2_rgb[11:8]};
  assign w_g8   = {4'd0, r_s2_rgb[7:4]};
  assign w_b8   = {4'd0, r_s2_rgb[3:0]};
  assign w_sum  = (w_r8 << 2) + w_r8 + (w_g8 << 3) + w_g8 + (w_b8 << 1);
  assign w_gray = w_sum[7:4];
  assign w_unused_lsb = ^w_sum[3:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gray <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_de   <= 1'b0;
      r_hs   <= 1'b1;
      r_vs   <= 1'b1;
      r_fs   <= 1'b0;
    end else begin
      r_gray <= r_s2_de ? {w_gray, w_gray, w_gray} : 12'd0;
      r_x    <= r_s2_x;
      r_y    <= r_s2_y;
      r_de   <= r_s2_de;
      r_hs   <= r_s2_hs;
      r_vs   <= r_s2_vs;
      r_fs   <= r_s2_fs;
    end
  end

  assign bus.rd_addr     = r_rd_addr;
  assign bus.rd_en       = r_rd_en;
  assign bus.gray_in     = r_gray;
  assign bus.x_coor      = r_x;
  assign bus.y_coor      = r_y;
  assign bus.de          = r_de;
  assign bus.hsync       = r_hs;
  assign bus.vsync       = r_vs;
  assign bus.frame_start = r_fs;

endmodule

// File: tb/tb_gray_pixel_source.sv
// Directed bench for gray_pixel_source using reduced timing parameters
// (32x13 total, 16x6 active) so several whole frames fit in a short run.
module tb_gray_pixel_source;

  localparam int HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   mem_mode = 0;
  int   stop_p = 1 << 30;

  gray_pixel_source_if bus();

  gray_pixel_source #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] mem_rgb(input logic [16:0] a, input int mode);
    if (mode == 0) return 12'hFFF;
    case (a[1:0])
      2'd0:    return 12'hF00;
      2'd1:    return 12'h0F0;
      2'd2:    return 12'h00F;
      default: return 12'h5A3;
    endcase
  endfunction

  // Hand-computed gray for each memory pattern: F00->4, 0F0->8, 00F->1, 5A3->7, FFF->15
  function automatic logic [11:0] gray_exp(input int a, input int mode);
    if (mode == 0) return 12'hFFF;
    case (a % 4)
      0:       return 12'h444;
      1:       return 12'h888;
      2:       return 12'h111;
      default: return 12'h777;
    endcase
  endfunction

  assign bus.rd_data = mem_rgb(bus.rd_addr, mem_mode);

  function automatic int addr_of(input int h, input int v);
    return (v / 2) * 320 + (h / 2);
  endfunction

  function automatic logic [34:0] exp_out(input int p);
    int pp, h, v;
    logic act, hs, vs, fs;
    logic [9:0] x;
    logic [8:0] y;
    logic [11:0] g;
    if (p < 0 || p >= stop_p) return {1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 9'd0, 12'd0};
    pp  = p % FT;
    h   = pp % HT;
    v   = pp / HT;
    act = (h < HA) && (v < VA);
    hs  = !((h >= HA + HF) && (h < HA + HF + HS));
    vs  = !((v >= VA + VF) && (v < VA + VF + VS));
    fs  = (pp == 0);
    x   = act ? 10'(h) : 10'd0;
    y   = act ? 9'(v) : 9'd0;
    g   = act ? gray_exp(addr_of(h, v), mem_mode) : 12'd0;
    return {act, hs, vs, fs, x, y, g};
  endfunction

  function automatic logic [17:0] exp_rd(input int p);
    int pp, h, v;
    if (p < 0 || p >= stop_p) return 18'd0;
    pp = p % FT;
    h  = pp % HT;
    v  = pp / HT;
    if (h < HA && v < VA) return {1'b1, 17'(addr_of(h, v))};
    return 18'd0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic check_cycle();
    chk("out_vec", {bus.de, bus.hsync, bus.vsync, bus.frame_start,
                    bus.x_coor, bus.y_coor, bus.gray_in}, exp_out(cyc - 3));
    chk("rd_port", {bus.rd_en, bus.rd_addr}, exp_rd(cyc - 1));
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_rd_addr"}, bus.rd_addr, 17'd0);
    chk({pfx, "_rd_en"}, bus.rd_en, 1'b0);
    chk({pfx, "_gray"}, bus.gray_in, 12'd0);
    chk({pfx, "_x"}, bus.x_coor, 10'd0);
    chk({pfx, "_y"}, bus.y_coor, 9'd0);
    chk({pfx, "_de"}, bus.de, 1'b0);
    chk({pfx, "_hsync"}, bus.hsync, 1'b1);
    chk({pfx, "_vsync"}, bus.vsync, 1'b1);
    chk({pfx, "_fs"}, bus.frame_start, 1'b0);
  endtask

  initial begin
    int fs_cnt, hs_low, hs_first, de_cnt, fs_last, fs_gap;
    bus.run = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");

    // Phase A: uniform white memory, release reset with run high
    reset = 1'b0;
    bus.run = 1'b1;
    cyc = 0;
    fs_cnt = 0; hs_low = 0; hs_first = -1; de_cnt = 0; fs_last = -1; fs_gap = 0;
    for (int i = 0; i < 2 * FT + 8; i++) begin
      step();
      check_cycle();
      if (cyc == 2) chk("fs_not_early", bus.frame_start, 1'b0);
      if (cyc == 3) chk("first_fs", {bus.frame_start, bus.de, bus.gray_in}, {2'b11, 12'hFFF});
      if (cyc == 1) chk("first_rd", {bus.rd_en, bus.rd_addr}, {1'b1, 17'd0});
      if (cyc == 99) chk("rd_addr_h2_v3", bus.rd_addr, 17'd321);
      if (cyc == 5 * HT + 15 + 1) chk("rd_addr_last", bus.rd_addr, 17'd647);
      if (bus.frame_start) begin
        fs_cnt++;
        if (fs_last >= 0 && fs_gap == 0) fs_gap = cyc - fs_last;
        fs_last = cyc;
      end
      if (cyc >= 3 && cyc < 3 + HT) begin
        if (bus.de) de_cnt++;
        if (!bus.hsync) begin
          hs_low++;
          if (hs_first < 0) hs_first = cyc - 3;
        end
      end
    end
    chk("fs_count", fs_cnt, 3);
    chk("fs_period", fs_gap, FT);
    chk("de_per_line", de_cnt, HA);
    chk("hsync_width", hs_low, HS);
    chk("hsync_start", hs_first, HA + HF);

    // Phase B: address-dependent colours, restart via reset, drop run at (10,3)
    mem_mode = 1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.run = 1'b1;
    cyc = 0;
    for (int i = 0; i < 120; i++) begin
      if (cyc == 3 * HT + 10) begin
        bus.run = 1'b0;
        stop_p = cyc;
      end
      step();
      check_cycle();
      if (cyc == 3 * HT + 10 + 2) chk("de_drain", bus.de, 1'b1);
      if (cyc == 3 * HT + 10 + 3) chk("de_off_3clk", {bus.de, bus.hsync, bus.vsync}, 3'b011);
    end

    // Reassert run: frame_start must appear on the third edge
    stop_p = 1 << 30;
    bus.run = 1'b1;
    cyc = 0;
    for (int i = 0; i < 150; i++) begin
      step();
      check_cycle();
      if (cyc == 3) chk("restart_fs", bus.frame_start, 1'b1);
    end

    // Asynchronous reset mid-line, checked before any clock edge
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("async_rst");
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      check_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
